// File: rtl/pwm_gen.sv
// pwm_gen: prescaled counter PWM with boundary-aligned duty/period shadow registers
module pwm_gen #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 8
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    input  logic [WIDTH-1:0]   period,
    input  logic [WIDTH-1:0]   duty_in,
    input  logic               duty_ld,
    output logic               duty_ack,
    output logic               pwm_d,
    output logic [WIDTH-1:0]   cnt,
    output logic               period_end
);
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   duty_sh_q, duty_sh_d;
    logic [WIDTH-1:0]   period_sh_q, period_sh_d;
    logic [WIDTH-1:0]   duty_pend_q, duty_pend_d;
    logic               pend_q, pend_d;
    logic               ack_q, ack_d;
    logic               pwm_lvl_q, pwm_lvl_d;
    logic               pe_q, pe_d;
    logic               tick, wrap, upd;

    // next state: disabled clocks act as shadow-update boundaries without counting
    always_comb begin
        tick        = en && (pcnt_q == presc);
        wrap        = tick && (cnt_q == period_sh_q);
        upd         = !en || wrap;
        pcnt_d      = (!en || tick) ? '0 : pcnt_q + 1'b1;
        cnt_d       = (!en || wrap) ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
        period_sh_d = upd ? period : period_sh_q;
        duty_sh_d   = (upd && pend_q) ? duty_pend_q : duty_sh_q;
        ack_d       = upd && pend_q;
        pend_d      = duty_ld || (pend_q && !upd);
        duty_pend_d = duty_ld ? duty_in : duty_pend_q;
        pwm_lvl_d   = en && (cnt_q < duty_sh_q);
        pe_d        = wrap;
    end

    // state registers with synchronous reset
    always_ff @(posedge ck) begin
        if (rst) begin
            pcnt_q      <= '0;
            cnt_q       <= '0;
            duty_sh_q   <= '0;
            period_sh_q <= '1;
            duty_pend_q <= '0;
            pend_q      <= 1'b0;
            ack_q       <= 1'b0;
            pwm_lvl_q   <= 1'b0;
            pe_q        <= 1'b0;
        end else begin
            pcnt_q      <= pcnt_d;
            cnt_q       <= cnt_d;
            duty_sh_q   <= duty_sh_d;
            period_sh_q <= period_sh_d;
            duty_pend_q <= duty_pend_d;
            pend_q      <= pend_d;
            ack_q       <= ack_d;
            pwm_lvl_q   <= pwm_lvl_d;
            pe_q        <= pe_d;
        end
    end

    assign duty_ack   = ack_q;
    assign pwm_d      = pwm_lvl_q;
    assign cnt        = cnt_q;
    assign period_end = pe_q;
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed checks of waveform shape, prescaling and shadow-load timing
module tb_pwm_gen;
    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] presc = '0;
    logic [7:0] period = 8'd9;
    logic [7:0] duty_in = '0;
    logic       duty_ld = 1'b0;
    logic       duty_ack, pwm_d, period_end;
    logic [7:0] cnt;
    int total = 0, bad = 0;
    int hi = 0, ak = 0, pe = 0;

    pwm_gen #(.WIDTH(8), .PRESC_W(8)) dut (
        .ck(ck), .rst(rst), .en(en), .presc(presc), .period(period),
        .duty_in(duty_in), .duty_ld(duty_ld), .duty_ack(duty_ack),
        .pwm_d(pwm_d), .cnt(cnt), .period_end(period_end)
    );

    // free-running clock
    always #5 ck = ~ck;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
        hi += int'(pwm_d);
        ak += int'(duty_ack);
        pe += int'(period_end);
    endtask

    task automatic clr();
        hi = 0;
        ak = 0;
        pe = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_pe(input int bound);
        for (int i = 0; i < bound; i++) begin
            step();
            if (period_end) return;
        end
        chk("pe_timeout", 0, 1);
    endtask

    task automatic setup(input int p, input int per, input int d);
        en = 1'b0;
        presc = 8'(p);
        period = 8'(per);
        duty_in = 8'(d);
        duty_ld = 1'b1;
        clr();
        step();
        duty_ld = 1'b0;
        run(2);
        chk("setup_ack", ak, 1);
        en = 1'b1;
    endtask

    initial begin
        run(2);
        chk("rst_pwm", pwm_d, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_ack", duty_ack, 0);
        chk("rst_pe", period_end, 0);
        rst = 1'b0;

        setup(0, 9, 3);
        run(4);
        duty_in = 8'd6;
        duty_ld = 1'b1;
        step();
        duty_ld = 1'b0;
        rst = 1'b1;
        clr();
        run(3);
        chk("midrst_pwm", pwm_d, 0);
        chk("midrst_cnt", cnt, 0);
        chk("midrst_pe", period_end, 0);
        rst = 1'b0;
        en = 1'b0;
        run(3);
        chk("midrst_noack", ak, 0);

        setup(0, 9, 3);
        step();
        chk("en_first_pwm", pwm_d, 1);
        chk("en_first_cnt", cnt, 1);
        clr();
        run(30);
        chk("basic_hi", hi, 9);
        chk("basic_pe", pe, 3);
        chk("basic_noack", ak, 0);
        wait_pe(20);
        clr();
        wait_pe(20);
        chk("basic_gap", hi + (10 - hi), 10);
        chk("basic_gap_pe", pe, 1);

        setup(2, 3, 2);
        wait_pe(40);
        for (int i = 1; i < 12; i++) begin
            step();
            chk("presc_cnt", cnt, i / 3);
            chk("presc_pwm", pwm_d, (i <= 6) ? 1 : 0);
        end
        step();
        chk("presc_wrap", period_end, 1);
        clr();
        run(48);
        chk("presc_hi", hi, 24);
        chk("presc_pe", pe, 4);

        setup(0, 9, 3);
        wait_pe(30);
        run(9);
        chk("align_cnt9", cnt, 9);
        duty_in = 8'd7;
        duty_ld = 1'b1;
        clr();
        step();
        duty_ld = 1'b0;
        chk("align_wrap", period_end, 1);
        step();
        step();
        duty_in = 8'd5;
        duty_ld = 1'b1;
        step();
        duty_ld = 1'b0;
        run(6);
        chk("align_old_hi", hi, 3);
        chk("align_old_ack", ak, 0);
        clr();
        step();
        chk("align_ack_now", duty_ack, 1);
        run(9);
        chk("align_new_hi", hi, 5);
        chk("align_one_ack", ak, 1);

        setup(0, 9, 0);
        clr();
        run(30);
        chk("duty0_hi", hi, 0);
        setup(0, 9, 200);
        clr();
        run(30);
        chk("duty200_hi", hi, 30);
        setup(0, 0, 1);
        clr();
        run(10);
        chk("per0_pe", pe, 10);
        chk("per0_hi", hi, 10);

        setup(0, 9, 3);
        wait_pe(30);
        run(7);
        chk("chg_cnt7", cnt, 7);
        period = 8'd4;
        run(2);
        chk("chg_cnt9", cnt, 9);
        step();
        chk("chg_wrap", period_end, 1);
        chk("chg_cnt0", cnt, 0);
        clr();
        run(4);
        chk("chg_cnt4", cnt, 4);
        step();
        chk("chg_short", period_end, 1);
        chk("chg_pe_once", pe, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_gen.md
# pwm_gen

Counter-based PWM generator for the PWM datapath. It takes a prescaler setting, a period and a duty-cycle request from the control side. It produces a registered PWM level, `pwm_d`, which drives the single-bit output retiming flop directly downstream. Duty and period changes pass through shadow registers and take effect only at a period boundary, so no runt or truncated pulses reach the output.

## Interface

- `WIDTH`, 8: width of the period counter, `period`, `duty_in` and `cnt`.
- `PRESC_W`, 8: width of the prescaler setting.

- `ck`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  run enable.
- `presc`  in  PRESC_W  tick divider; the counter advances once every `presc+1` clocks.
- `period`  in  WIDTH  terminal count; one PWM period is `period+1` ticks. Sampled at boundaries only.
- `duty_in`  in  WIDTH  requested high time, in ticks.
- `duty_ld`  in  1  single-cycle strobe; captures `duty_in`.
- `duty_ack`  out  1  one-cycle pulse when a captured duty value becomes active.
- `pwm_d`  out  1  registered PWM level; feeds the downstream output flop.
- `cnt`  out  WIDTH  current period counter value.
- `period_end`  out  1  one-cycle pulse on each counter wrap.

## Operation

**Reset** (`rst`=1 at a clock edge, which overrides everything):
- Registers: `pcnt`=0, `cnt`=0, `duty_sh`=0, `period_sh`=all-ones, `pend`=0, `duty_pend`=0.
- Outputs: `pwm_d`=0, `duty_ack`=0, `period_end`=0.
- Reset mid-period discards any pending duty value; no ack is issued for it.

**Prescaler:**
- `pcnt` counts 0..`presc`; `tick`=(`pcnt`==`presc`) && `en`.
- On `tick`, `pcnt` returns to 0. `presc`=0 gives a tick every clock.
- `presc` is sampled live. If it is lowered below `pcnt`, `pcnt` continues counting and wraps through all-ones (modulo 2^PRESC_W); this is not a hang.

**Counter:**
- On `tick`: if `cnt`==`period_sh` then `cnt`<=0 (this is a boundary); otherwise `cnt`<=`cnt`+1.
- `period_end`<=1 for exactly the clock following a boundary edge.

**Load handshake:**
- `duty_ld`=1 sets `duty_pend`<=`duty_in` and `pend`<=1.
- A second `duty_ld` before the boundary overwrites `duty_pend`; the last value wins and only one ack is issued.
- At a boundary: `period_sh`<=`period`. If `pend`=1, then `duty_sh`<=`duty_pend`, `pend`<=0 and `duty_ack`<=1 for one cycle.
- If `duty_ld` and a boundary occur in the same cycle, the new value goes to `duty_pend` and is applied at the next boundary; the current boundary uses the old pending state.

**Disabled** (`en`=0):
- `pcnt` and `cnt` clear to 0 synchronously and `pwm_d`<=0.
- Every clock is treated as a boundary for the shadow update only: `period_sh` follows `period`, and a pending duty transfers with `duty_ack`.
- `period_end` stays 0.

**Output:**
- `pwm_d`<=`en` && (`cnt` < `duty_sh`), unsigned compare.
- `duty_sh`=0 gives a constant 0. `duty_sh`>`period_sh` gives a constant 1 (100%).

## Timing

- Period length is (`period_sh`+1)·(`presc`+1) clocks. High time is min(`duty_sh`, `period_sh`+1)·(`presc`+1) clocks.
- `pwm_d` lags `cnt` by one clock. The downstream flop adds one more, so pin latency from a `cnt` change is 2 clocks.
- `duty_ack` and `period_end` assert in the same clock, the one after the boundary edge. The new `duty_sh` is visible on `pwm_d` one clock after that.
- After `en` rises, the first tick occurs `presc`+1 clocks later. `pwm_d` goes high one clock after `en` is sampled high, provided `duty_sh`>0.
- The maximum duty-load-to-ack latency is one full period plus one clock.

## Test plan

1. **Reset values:** hold `rst` for 3 clocks mid-run with a load pending. Required: all outputs 0, `cnt`=0, and no `duty_ack` afterwards.
2. **Basic waveform:** WIDTH=8, `presc`=0, `period`=9, `duty_ld` with 3 while disabled, then `en`=1. Required: `duty_ack` pulses while disabled; `pwm_d` repeats 3 high / 7 low; `period_end` pulses every 10 clocks.
3. **Prescaler:** `presc`=2, `period`=3, duty 2. Required: period of 12 clocks, 6 high; `cnt` holds each value for 3 clocks.
4. **Boundary-aligned load:** running at duty 3 with `period`=9, strobe `duty_ld`=7 exactly on a wrap cycle, and again with 5 two cycles later. Required: the current period keeps duty 3; the next period shows 5 high; exactly one `duty_ack`.
5. **Extremes:** duty 0 gives `pwm_d` constantly 0. Duty 200 with `period`=9 gives `pwm_d` constantly 1 with no low glitch at the wrap. `period`=0 gives `period_end` every clock.
6. **Period change mid-run:** `period` changes from 9 to 4 while `cnt`=7. Required: the counter still reaches 9 and wraps; the next period is 5 ticks long.
